// File: rtl/stall_ctrl_pkg.sv
// Shared opcode constants, FSM state type and stall-source encoding for the
// stall controller and the hazard unit.
package stall_ctrl_pkg;

  localparam logic [4:0] OPC_HLT     = 5'b10001;
  localparam logic [4:0] OPC_LD      = 5'b10100;
  localparam logic [2:0] OPC_JMP_PFX = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_WAIT  = 2'd1,
    JMP_WAIT = 2'd2,
    HALT     = 2'd3
  } state_e;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_LD   = 2'b01;
  localparam logic [1:0] SRC_JMP  = 2'b10;
  localparam logic [1:0] SRC_HALT = 2'b11;

endpackage

// File: rtl/stall_decode.sv
// Opcode classifier: flags halt, load and jump instructions (HLT > LD > JUMP).
module stall_decode
  import stall_ctrl_pkg::*;
(
  input  logic [4:0] op,
  output logic       hlt,
  output logic       ld,
  output logic       jmp
);

  always_comb begin
    hlt = (op == OPC_HLT);
    ld  = !hlt && (op == OPC_LD);
    jmp = !hlt && !ld && (op[4:2] == OPC_JMP_PFX);
  end

endmodule

// File: rtl/stall_ctrl_gen.sv
// Pipeline stall controller: programmable load/jump stall depth, halt until
// resume, stall source flag. STALL_CTRL_PERF_EN adds a saturating stall-cycle counter.
module stall_ctrl_gen
  import stall_ctrl_pkg::*;
#(
  parameter int INS_W     = 24,
  parameter int LD_STALL  = 1,
  parameter int JMP_STALL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INS_W-1:0] ins,
  input  logic             resume,
  output logic             stall,
  output logic             stall_pm,
  output logic [1:0]       stall_src
`ifdef STALL_CTRL_PERF_EN
  ,
  output logic [15:0]      perf_stall_cnt
`endif
);

  // state    | meaning
  // IDLE     | decoding ins every cycle
  // LD_WAIT  | load stall in progress, cnt cycles left, then one masked cycle
  // JMP_WAIT | jump stall in progress, cnt cycles left, then one masked cycle
  // HALT     | held until resume

  localparam int MAX_STALL = (LD_STALL > JMP_STALL) ? LD_STALL : JMP_STALL;
  localparam int CNT_W     = $clog2(MAX_STALL + 1);

  logic             is_hlt, is_ld, is_jmp;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_pm_q, stall_pm_d;

  stall_decode u_decode (
    .op  (ins[INS_W-1 -: 5]),
    .hlt (is_hlt),
    .ld  (is_ld),
    .jmp (is_jmp)
  );

  if (INS_W > 5) begin : g_ins_low
    logic unused_ins_low;
    assign unused_ins_low = ^ins[INS_W-6:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    stall_src = SRC_NONE;
    unique case (state_q)
      IDLE: begin
        if (is_hlt) begin
          stall     = 1'b1;
          stall_src = SRC_HALT;
          state_d   = HALT;
        end else if (is_ld) begin
          stall     = 1'b1;
          stall_src = SRC_LD;
          cnt_d     = CNT_W'(LD_STALL - 1);
          state_d   = LD_WAIT;
        end else if (is_jmp) begin
          stall     = 1'b1;
          stall_src = SRC_JMP;
          cnt_d     = CNT_W'(JMP_STALL - 1);
          state_d   = JMP_WAIT;
        end
      end
      // At cnt==0 the still-held instruction is ignored so it is not re-decoded.
      LD_WAIT, JMP_WAIT: begin
        if (cnt_q != '0) begin
          stall     = 1'b1;
          stall_src = (state_q == LD_WAIT) ? SRC_LD : SRC_JMP;
          cnt_d     = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      HALT: begin
        if (resume) begin
          state_d = IDLE;
        end else begin
          stall     = 1'b1;
          stall_src = SRC_HALT;
        end
      end
      default: state_d = IDLE;
    endcase
    stall_pm_d = stall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stall_pm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stall_pm_q <= stall_pm_d;
    end
  end

  assign stall_pm = stall_pm_q;

`ifdef STALL_CTRL_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (stall && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule
